game_sequencer: RTL

Top-level match controller for the pong design, sitting between the ball module and the score display. It sequences the game through idle, serve delay, live play, point hold and game over. It owns the ball's reset and run enable, keeps both players' score counters, and detects the winning condition. It runs on the pixel clock and counts time in frames, using a one-cycle frame tick.

---
 rtl/pong_pkg.sv | 51 +++++
 rtl/button_sync.sv | 36 +++
 rtl/game_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: definitions shared across the pong design.
//   game_state_t  - match sequencer states
//   SCORE_W       - width of each player's score counter
//   SERVE_LEFT /
//   SERVE_RIGHT   - encoding of the serve_dir output
//   sat_inc()     - score increment that sticks at a limit
//   max3()        - largest of three integers, used to size frame counters
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        POINT     = 3'd3,
        GAME_OVER = 3'd4
    } game_state_t;

    localparam int SCORE_W = 4;

    localparam logic SERVE_LEFT  = 1'b0;
    localparam logic SERVE_RIGHT = 1'b1;

    localparam logic [SCORE_W-1:0] SCORE_ONE = {{(SCORE_W-1){1'b0}}, 1'b1};

    // Increment a score but never step past the limit, so counters cannot wrap.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] val,
                                                   input logic [SCORE_W-1:0] limit);
        if (val < limit) begin
            sat_inc = val + SCORE_ONE;
        end else begin
            sat_inc = val;
        end
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

endpackage

// File: rtl/button_sync.sv
// button_sync: brings a raw active-low button into the clock domain through a
// two-flop synchroniser and flags a press (1->0 on the synchronised level).
// Ports:
//   clk      - sampling clock
//   reset    - synchronous, active-low reset (chain resets to "released")
//   i_btn_n  - raw active-low button level
//   o_press  - one-cycle pulse for each synchronised press
module button_sync
    import pong_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_btn_n,
    output logic o_press
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;

    // Synchroniser chain plus one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_meta   <= 1'b1;
            r_sync   <= 1'b1;
            r_sync_d <= 1'b1;
        end else begin
            r_meta   <= i_btn_n;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    assign o_press = r_sync_d & ~r_sync;

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: match controller for pong. Sequences IDLE -> SERVE -> PLAY ->
// POINT/GAME_OVER, drives the ball's reset/run, keeps both scores and the
// winner. Time is counted in frame_tick pulses.
// Optional feature macro: PONG_AUTO_RESTART_EN - GAME_OVER also returns to
// IDLE after OVER_FRAMES ticks (scores stay visible until the next press).
// Ports:
//   clk, reset (sync, active-low), frame_tick (1 pulse/frame),
//   start_n (raw active-low start button), score_left/score_right (point
//   events from the ball), ball_reset, ball_run, left_score, right_score,
//   serve_dir (0 = toward left), game_over, winner (0 = left, valid with
//   game_over). All outputs are registered.
module game_sequencer
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30,
    parameter int OVER_FRAMES  = 300
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start_n,
    input  logic               score_left,
    input  logic               score_right,
    output logic               ball_reset,
    output logic               ball_run,
    output logic [SCORE_W-1:0] left_score,
    output logic [SCORE_W-1:0] right_score,
    output logic               serve_dir,
    output logic               game_over,
    output logic               winner
);

    localparam int CNT_W = $clog2(max3(SERVE_FRAMES, POINT_FRAMES, OVER_FRAMES)) + 1;
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
`ifdef PONG_AUTO_RESTART_EN
    localparam logic [CNT_W-1:0]   OVER_LAST  = CNT_W'(OVER_FRAMES - 1);
`endif
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

    game_state_t        r_state;
    game_state_t        w_next_state;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic [CNT_W-1:0]   w_frame_cnt_next;

    logic               w_press;
    logic               r_sc_left;
    logic               r_sc_right;
    logic               r_sc_any_d;
    logic               w_sc_rise;
    logic               w_left_only;
    logic               w_right_only;
    logic [SCORE_W-1:0] w_left_inc;
    logic [SCORE_W-1:0] w_right_inc;

    logic               r_ball_reset;
    logic               r_ball_run;
    logic [SCORE_W-1:0] r_left_score;
    logic [SCORE_W-1:0] r_right_score;
    logic               r_serve_dir;
    logic               r_game_over;
    logic               r_winner;

    logic [SCORE_W-1:0] w_left_nxt;
    logic [SCORE_W-1:0] w_right_nxt;
    logic               w_dir_nxt;
    logic               w_win_cand;
    logic               w_winner_nxt;

    button_sync u_start_sync (
        .clk     (clk),
        .reset   (reset),
        .i_btn_n (start_n),
        .o_press (w_press)
    );

    // Register the raw score inputs so a held level produces a single rising edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sc_left  <= 1'b0;
            r_sc_right <= 1'b0;
            r_sc_any_d <= 1'b0;
        end else begin
            r_sc_left  <= score_left;
            r_sc_right <= score_right;
            r_sc_any_d <= r_sc_left | r_sc_right;
        end
    end

    assign w_sc_rise    = (r_sc_left | r_sc_right) & ~r_sc_any_d;
    assign w_left_only  = r_sc_left & ~r_sc_right;
    assign w_right_only = r_sc_right & ~r_sc_left;
    assign w_left_inc   = sat_inc(r_left_score, WIN_VAL);
    assign w_right_inc  = sat_inc(r_right_score, WIN_VAL);

    // State register and frame counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_frame_cnt <= {CNT_W{1'b0}};
        end else begin
            r_state     <= w_next_state;
            r_frame_cnt <= w_frame_cnt_next;
        end
    end

    // Next-state logic; frame counter restarts from zero on every state change.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_press) begin
                    w_next_state = SERVE;
                end else begin
                    w_next_state = IDLE;
                end
            end
            SERVE: begin
                if (frame_tick && (r_frame_cnt == SERVE_LAST)) begin
                    w_next_state = PLAY;
                end else begin
                    w_next_state = SERVE;
                end
            end
            PLAY: begin
                if (!w_sc_rise) begin
                    w_next_state = PLAY;
                end else if (w_left_only && (w_left_inc == WIN_VAL)) begin
                    w_next_state = GAME_OVER;
                end else if (w_right_only && (w_right_inc == WIN_VAL)) begin
                    w_next_state = GAME_OVER;
                end else begin
                    w_next_state = POINT;
                end
            end
            POINT: begin
                if (frame_tick && (r_frame_cnt == POINT_LAST)) begin
                    w_next_state = SERVE;
                end else begin
                    w_next_state = POINT;
                end
            end
            GAME_OVER: begin
                if (w_press) begin
                    w_next_state = SERVE;
`ifdef PONG_AUTO_RESTART_EN
                end else if (frame_tick && (r_frame_cnt == OVER_LAST)) begin
                    w_next_state = IDLE;
`endif
                end else begin
                    w_next_state = GAME_OVER;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        if (w_next_state != r_state) begin
            w_frame_cnt_next = {CNT_W{1'b0}};
`ifdef PONG_AUTO_RESTART_EN
        end else if (frame_tick && ((r_state == SERVE) || (r_state == POINT) ||
                                    (r_state == GAME_OVER))) begin
`else
        end else if (frame_tick && ((r_state == SERVE) || (r_state == POINT))) begin
`endif
            w_frame_cnt_next = r_frame_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            w_frame_cnt_next = r_frame_cnt;
        end
    end

    // Next values of the registered outputs (scores, serve direction, winner).
    always_comb begin
        w_left_nxt  = r_left_score;
        w_right_nxt = r_right_score;
        w_dir_nxt   = r_serve_dir;
        w_win_cand  = r_winner;
        case (r_state)
            IDLE, GAME_OVER: begin
                if (w_press) begin
                    w_left_nxt  = {SCORE_W{1'b0}};
                    w_right_nxt = {SCORE_W{1'b0}};
                end else begin
                    w_left_nxt  = r_left_score;
                    w_right_nxt = r_right_score;
                end
            end
            PLAY: begin
                if (!w_sc_rise) begin
                    w_dir_nxt = r_serve_dir;
                end else if (w_left_only) begin
                    w_left_nxt = w_left_inc;
                    w_dir_nxt  = SERVE_RIGHT;
                    w_win_cand = 1'b0;
                end else if (w_right_only) begin
                    w_right_nxt = w_right_inc;
                    w_dir_nxt   = SERVE_LEFT;
                    w_win_cand  = 1'b1;
                end else begin
                    // Simultaneous points cancel out; only the serve flips.
                    w_dir_nxt = ~r_serve_dir;
                end
            end
            default: begin
                w_dir_nxt = r_serve_dir;
            end
        endcase

        if (w_next_state == GAME_OVER) begin
            w_winner_nxt = w_win_cand;
        end else begin
            w_winner_nxt = 1'b0;
        end
    end

    // Output registers; ball controls follow the state being entered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ball_reset  <= 1'b1;
            r_ball_run    <= 1'b0;
            r_left_score  <= {SCORE_W{1'b0}};
            r_right_score <= {SCORE_W{1'b0}};
            r_serve_dir   <= SERVE_LEFT;
            r_game_over   <= 1'b0;
            r_winner      <= 1'b0;
        end else begin
            r_ball_reset  <= (w_next_state != PLAY);
            r_ball_run    <= (w_next_state == PLAY);
            r_left_score  <= w_left_nxt;
            r_right_score <= w_right_nxt;
            r_serve_dir   <= w_dir_nxt;
            r_game_over   <= (w_next_state == GAME_OVER);
            r_winner      <= w_winner_nxt;
        end
    end

    assign ball_reset  = r_ball_reset;
    assign ball_run    = r_ball_run;
    assign left_score  = r_left_score;
    assign right_score = r_right_score;
    assign serve_dir   = r_serve_dir;
    assign game_over   = r_game_over;
    assign winner      = r_winner;

endmodule
